// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_responder
// Description : Main-memory responder for the 2-way data cache. Serves refill
//               reads and dirty-line writebacks over one valid/ready request
//               channel. The backing array sits behind a fixed LATENCY, and a
//               one-entry posted write buffer acks writebacks quickly. It also
//               forwards a refill read to the buffered address from the buffer.
// Ports       : clk        - single clock, all state changes on posedge
//               rst_n      - asynchronous active-low reset
//               req_valid  - cache presents a request
//               req_wr     - 1 = writeback, 0 = refill read
//               req_addr   - byte address, word index = [ADDR_WIDTH+1:2]
//               req_wdata  - writeback data
//               req_ready  - request can be accepted this cycle (combinational)
//               resp_valid - one-cycle pulse: read data valid / write acked
//               resp_rdata - read data, holds its value between responses
//               busy       - FSM not idle or write buffer occupied
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Counter only ever has to hold LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    wb_full_q, wb_full_d;
  logic [ADDR_WIDTH-1:0]   wb_idx_q, wb_idx_d;
  logic [31:0]             wb_data_q, wb_data_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    mem_we;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    unused_addr;

  // Backing store; deliberately not reset.
  logic [31:0]             mem [DEPTH];

  // Upper address bits alias onto the array; byte-offset bits are ignored.
  assign req_idx     = req_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  // A write cannot enter a full buffer; it waits for the forced drain.
  assign req_ready  = (state_q == IDLE) && !(req_wr && wb_full_q);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign busy       = (state_q != IDLE) || wb_full_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wb_full_d = wb_full_q;
    wb_idx_d  = wb_idx_q;
    wb_data_d = wb_data_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        // An accepted request always wins over a pending drain.
        if (accept) begin
          if (req_wr) begin
            wb_full_d = 1'b1;
            wb_idx_d  = req_idx;
            wb_data_d = req_wdata;
            state_d   = RESP;
          end else if (wb_full_q && (wb_idx_q == req_idx)) begin
            rdata_d = wb_data_q;
            state_d = RESP;
          end else begin
            idx_d   = req_idx;
            cnt_d   = CNT_LOAD;
            state_d = READ;
          end
        end else if (wb_full_q) begin
          cnt_d   = CNT_LOAD;
          state_d = DRAIN;
        end
      end

      READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d = mem[idx_q];
          state_d = RESP;
        end
      end

      DRAIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we    = 1'b1;
          wb_full_d = 1'b0;
          state_d   = IDLE;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wb_full_q <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wb_full_q <= wb_full_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wb_idx_q] <= wb_data_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_responder
// Description : Self-checking bench for cache_mem_responder. A reference model
//               treats memory as "latest value written per word index" and
//               tracks whether a posted write is still waiting to drain, from
//               which it predicts stall length, response edge and read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_responder;

  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 4;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          pend_v   = 1'b0;
  int          pend_idx = 0;
  logic [31:0] last_rd  = '0;
  logic [31:0] old16;
  logic [31:0] old32;

  cache_mem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LATENCY   (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2ms", $time);
    $fatal(1);
  end

  // Expected behaviour of one request, from the model. ew = cycles the request
  // is held off, el = index of the edge (counting the accept edge as 0) at
  // which the cache captures the response pulse, ed = resp_rdata at that edge.
  task automatic predict(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output int ew, output int el, output logic [31:0] ed);
    int idx;
    idx = int'((a >> 2) % 32'(DEPTH));
    if (wr) begin
      // a full buffer must drain (LATENCY edges) before the write fits
      ew = pend_v ? LATENCY + 1 : 0;
      el = 1;
      ed = last_rd;
      ref_mem[idx] = d;
      pend_v   = 1'b1;
      pend_idx = idx;
    end else begin
      ew = 0;
      el = (pend_v && pend_idx == idx) ? 1 : LATENCY + 1;
      ed = ref_mem[idx];
      last_rd = ed;
    end
  endtask

  // Quiet cycles; a long enough gap lets any posted write drain.
  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
    if (n >= LATENCY + 1) pend_v = 1'b0;
  endtask

  // Drive one request starting at a negedge; returns observations only.
  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output int waits, output int lat, output logic [31:0] rd,
                      output bit after_hi, output bit busy_low, output bit tmo);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    waits = 0; lat = 0; rd = '0; after_hi = 1'b0; busy_low = 1'b0; tmo = 1'b0;
    #1;
    while (!req_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      tmo = 1'b1;
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      while (lat < 200) begin
        @(negedge clk);
        lat++;
        if (!busy) busy_low = 1'b1;
        if (resp_valid) break;
      end
      if (!resp_valid) tmo = 1'b1;
      rd = resp_rdata;
      @(negedge clk);
      after_hi = resp_valid;
    end
  endtask

  task automatic test_reset();
    bit seen;
    #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
    // start a read, then abort it with reset while it is in flight
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h14;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy_inflight: got %b want 1", busy); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_async_rdata: got %h want 0", resp_rdata); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rst_no_resp: got pulse=%b want 0", seen); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_rdata_after: got %h want 0", resp_rdata); else n_pass++;
  endtask

  task automatic test_uncached_read();
    int ew, el, w, l; logic [31:0] ed, rd; bit ah, bl, tmo;
    predict(1'b0, 32'h14, 32'h0, ew, el, ed);
    xact(1'b0, 32'h14, 32'h0, w, l, rd, ah, bl, tmo);
    n_checks++; if (tmo) $display("FAIL rd_timeout: got timeout want response"); else n_pass++;
    n_checks++; if (w !== ew) $display("FAIL rd_wait: got %0d want %0d", w, ew); else n_pass++;
    n_checks++; if (l !== el) $display("FAIL rd_latency: got %0d want %0d", l, el); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (ah !== 1'b0) $display("FAIL rd_pulse_width: got %b want 0", ah); else n_pass++;
  endtask

  task automatic test_write_forward();
    int ew, el, w, l; logic [31:0] ed, rd; bit ah, bl, tmo;
    old16 = ref_mem[16];
    predict(1'b1, 32'h40, 32'h12345678, ew, el, ed);
    xact(1'b1, 32'h40, 32'h12345678, w, l, rd, ah, bl, tmo);
    n_checks++; if (tmo) $display("FAIL wr_timeout: got timeout want ack"); else n_pass++;
    n_checks++; if (l !== el) $display("FAIL wr_latency: got %0d want %0d", l, el); else n_pass++;
    n_checks++; if (rd !== ed) $display("FAIL wr_rdata_hold: got %h want %h", rd, ed); else n_pass++;
    n_checks++; if (ah !== 1'b0) $display("FAIL wr_pulse_width: got %b want 0", ah); else n_pass++;
    predict(1'b0, 32'h40, 32'h0, ew, el, ed);
    xact(1'b0, 32'h40, 32'h0, w, l, rd, ah, bl, tmo);
    n_checks++; if (l !== el) $display("FAIL fwd_latency: got %0d want %0d", l, el); else n_pass++;
    n_checks++; if (rd !== 32'h12345678) $display("FAIL fwd_data: got %h want 12345678", rd); else n_pass++;
    n_checks++; if (dut.mem[16] !== old16) $display("FAIL fwd_mem_old: got %h want %h", dut.mem[16], old16); else n_pass++;
  endtask

  task automatic test_full_stall();
    int ew, el, w, l; logic [31:0] ed, rd; bit ah, bl, tmo;
    old32 = ref_mem[32];
    predict(1'b1, 32'h80, 32'hA5A5_0080, ew, el, ed);
    xact(1'b1, 32'h80, 32'hA5A5_0080, w, l, rd, ah, bl, tmo);
    n_checks++; if (tmo) $display("FAIL stall_timeout: got timeout want ack"); else n_pass++;
    n_checks++; if (w !== ew) $display("FAIL stall_wait: got %0d want %0d", w, ew); else n_pass++;
    n_checks++; if (l !== el) $display("FAIL stall_latency: got %0d want %0d", l, el); else n_pass++;
    n_checks++; if (dut.mem[16] !== 32'h12345678) $display("FAIL stall_drained: got %h want 12345678", dut.mem[16]); else n_pass++;
  endtask

  task automatic test_read_priority();
    int ew, el, w, l; logic [31:0] ed, rd; bit ah, bl, tmo, bad;
    predict(1'b0, 32'h14, 32'h0, ew, el, ed);
    xact(1'b0, 32'h14, 32'h0, w, l, rd, ah, bl, tmo);
    n_checks++; if (w !== 0) $display("FAIL prio_wait: got %0d want 0", w); else n_pass++;
    n_checks++; if (l !== el) $display("FAIL prio_latency: got %0d want %0d", l, el); else n_pass++;
    n_checks++; if (rd !== ed) $display("FAIL prio_data: got %h want %h", rd, ed); else n_pass++;
    n_checks++; if (bl !== 1'b0) $display("FAIL prio_busy_during_read: got low=%b want 0", bl); else n_pass++;
    // buffered write drains once the channel goes quiet
    bad = 1'b0;
    repeat (LATENCY) begin
      @(negedge clk);
      if (busy !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL prio_busy_drain: got low want 1"); else n_pass++;
    n_checks++; if (dut.mem[32] !== old32) $display("FAIL prio_mem_pre: got %h want %h", dut.mem[32], old32); else n_pass++;
    @(negedge clk);
    pend_v = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL prio_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (dut.mem[32] !== 32'hA5A5_0080) $display("FAIL prio_mem_post: got %h want a5a50080", dut.mem[32]); else n_pass++;
  endtask

  task automatic test_alias();
    int ew, el, w, l; logic [31:0] ed, rd; bit ah, bl, tmo;
    predict(1'b1, 32'h1000, 32'hCAFEF00D, ew, el, ed);
    xact(1'b1, 32'h1000, 32'hCAFEF00D, w, l, rd, ah, bl, tmo);
    idle(LATENCY + 3);
    n_checks++; if (dut.mem[0] !== 32'hCAFEF00D) $display("FAIL alias_mem: got %h want cafef00d", dut.mem[0]); else n_pass++;
    predict(1'b0, 32'h0, 32'h0, ew, el, ed);
    xact(1'b0, 32'h0, 32'h0, w, l, rd, ah, bl, tmo);
    n_checks++; if (l !== el) $display("FAIL alias_latency: got %0d want %0d", l, el); else n_pass++;
    n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL alias_data: got %h want cafef00d", rd); else n_pass++;
  endtask

  task automatic test_random();
    int ew, el, w, l; logic [31:0] ed, rd, a, d; bit ah, bl, tmo, wr;
    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom_range(0, 1));
      // few indices so forwarding and stalls are common; random upper bits alias
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      d = $urandom;
      predict(wr, a, d, ew, el, ed);
      xact(wr, a, d, w, l, rd, ah, bl, tmo);
      n_checks++; if (tmo) $display("FAIL rnd_timeout[%0d]: got timeout want response", t); else n_pass++;
      n_checks++; if (w !== ew) $display("FAIL rnd_wait[%0d]: got %0d want %0d", t, w, ew); else n_pass++;
      n_checks++; if (l !== el) $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, l, el); else n_pass++;
      n_checks++; if (rd !== ed) $display("FAIL rnd_rdata[%0d]: got %h want %h", t, rd, ed); else n_pass++;
      n_checks++; if (ah !== 1'b0) $display("FAIL rnd_pulse_width[%0d]: got %b want 0", t, ah); else n_pass++;
      if ($urandom_range(0, 3) == 0) idle(LATENCY + 3);
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      dut.mem[i] = v;
      ref_mem[i] = v;
    end
    dut.mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_uncached_read();
    test_write_forward();
    test_full_stall();
    test_read_priority();
    test_alias();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
